// File: rtl/sha1_pkg.sv
// sha1_pkg: shared types and constants for the SHA-1 padder and its block core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha1_pkg;

    localparam int WORD_W = 32;
    localparam int BLK_W  = 512;

    localparam logic [159:0] SHA1_IV =
        160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;

    localparam logic [7:0]        SHA1_PAD_MARK  = 8'h80;
    localparam logic [WORD_W-1:0] SHA1_MARK_WORD = {SHA1_PAD_MARK, 24'h000000};

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_PAD    = 2'd1,
        ST_LEN    = 2'd2,
        ST_EMIT   = 2'd3
    } pad_state_t;

    // Bit offset of block word 'widx'; word 0 sits in the top 32 bits.
    function automatic logic [8:0] word_lsb(input logic [3:0] widx);
        return {4'd15 - widx, 5'd0};
    endfunction

endpackage

// File: rtl/sha1_pad_merge.sv
// sha1_pad_merge: keeps the valid leading bytes of a last word and appends the 0x80 marker.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs. Compiled only with SHA1_PADDER_BYTE_EN.
`ifdef SHA1_PADDER_BYTE_EN
module sha1_pad_merge
    import sha1_pkg::*;
(
    input  logic [WORD_W-1:0] in_data,
    input  logic [1:0]        in_bytes,
    output logic [WORD_W-1:0] out_word
);

    // Bytes past the valid count are dropped; the marker takes the first free byte.
    // A full word (count 0 = 4 bytes) passes through untouched.
    always_comb begin
        out_word = in_data;
        case (in_bytes)
            2'd1:    out_word = {in_data[31:24], SHA1_PAD_MARK, 16'h0000};
            2'd2:    out_word = {in_data[31:16], SHA1_PAD_MARK, 8'h00};
            2'd3:    out_word = {in_data[31:8],  SHA1_PAD_MARK};
            default: out_word = in_data;
        endcase
    end

endmodule
`endif

// File: rtl/sha1_padder.sv
// sha1_padder: SHA-1 padder turning a 32-bit big-endian word stream into 512-bit blocks.
// Latency: one word per cycle; final block valid (14 - widx_after) + 3 cycles after the last word.
// Backpressure: in_ready low outside ACCEPT; block and flags held until blk_ready. Option: SHA1_PADDER_BYTE_EN.
module sha1_padder
    import sha1_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_last,
    input  logic [1:0]        in_bytes,
    output logic              blk_valid,
    input  logic              blk_ready,
    output logic [BLK_W-1:0]  block,
    output logic              blk_first,
    output logic              blk_final
);

    pad_state_t        state_q, state_d;
    logic [3:0]        widx_q, widx_d;
    logic [BLK_W-1:0]  buf_q, buf_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              pend80_q, pend80_d;
    logic              need_len_q, need_len_d;
    logic              first_q, first_d;
    logic              final_q, final_d;
    logic              in_ready_q, in_ready_d;

    logic              in_acc;
    logic              blk_hs;
    logic [WORD_W-1:0] last_dat;
    logic              last_full;
    logic [2:0]        last_nbytes;
    logic [LEN_W-1:0]  len_inc;
    logic [63:0]       len64;
    logic              wr_en;
    logic [WORD_W-1:0] wr_dat;

    assign in_acc = in_valid & in_ready_q;
    assign blk_hs = (state_q == ST_EMIT) & blk_ready;
    assign len64  = 64'(len_q);

`ifdef SHA1_PADDER_BYTE_EN
    // Byte-granular last word: the merge places the marker inside the word
    // unless all four bytes are valid, in which case it is deferred.
    sha1_pad_merge u_merge (
        .in_data  (in_data),
        .in_bytes (in_bytes),
        .out_word (last_dat)
    );
    assign last_full   = (in_bytes == 2'd0);
    assign last_nbytes = last_full ? 3'd4 : {1'b0, in_bytes};
`else
    // Word-granular last word: always four bytes, marker always deferred.
    logic unused_in_bytes;
    assign unused_in_bytes = ^in_bytes;
    assign last_dat        = in_data;
    assign last_full       = 1'b1;
    assign last_nbytes     = 3'd4;
`endif

    assign len_inc = in_last ? LEN_W'({last_nbytes, 3'b000}) : LEN_W'(32);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: when a block fills up, and where padding continues after the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: begin
                if (in_acc) begin
                    if (widx_q == 4'd15) begin
                        state_d = ST_EMIT;
                    end else if (in_last) begin
                        // Marker already in word 13: words 14/15 are free for the length.
                        if (widx_q == 4'd13 && !last_full) begin
                            state_d = ST_LEN;
                        end else begin
                            state_d = ST_PAD;
                        end
                    end
                end
            end
            ST_PAD: begin
                // Only an overflowing marker reaches word 15 here; otherwise stop at 13.
                if (widx_q == 4'd15) begin
                    state_d = ST_EMIT;
                end else if (widx_q == 4'd13) begin
                    state_d = ST_LEN;
                end
            end
            ST_LEN: begin
                if (widx_q == 4'd15) begin
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (blk_ready) begin
                    state_d = (need_len_q || pend80_q) ? ST_PAD : ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Outputs: block and flags come straight from registers, never from blk_ready.
    always_comb begin
        in_ready  = in_ready_q;
        blk_valid = (state_q == ST_EMIT);
        blk_first = (state_q == ST_EMIT) & first_q;
        blk_final = (state_q == ST_EMIT) & final_q;
        block     = buf_q;
    end

    // Datapath: word writes into the buffer, length accumulation and pending-marker bookkeeping.
    always_comb begin
        widx_d     = widx_q;
        buf_d      = buf_q;
        len_d      = len_q;
        pend80_d   = pend80_q;
        need_len_d = need_len_q;
        first_d    = first_q;
        final_d    = final_q;
        wr_en      = 1'b0;
        wr_dat     = '0;
        case (state_q)
            ST_ACCEPT: begin
                if (in_acc) begin
                    wr_en  = 1'b1;
                    wr_dat = in_last ? last_dat : in_data;
                    len_d  = len_q + len_inc;
                    widx_d = widx_q + 4'd1;
                    if (in_last) begin
                        pend80_d = last_full;
                        // Marker landed in word 15: the length needs a block of its own.
                        if (widx_q == 4'd15 && !last_full) begin
                            need_len_d = 1'b1;
                        end
                    end
                end
            end
            ST_PAD: begin
                wr_en    = 1'b1;
                wr_dat   = pend80_q ? SHA1_MARK_WORD : '0;
                pend80_d = 1'b0;
                widx_d   = widx_q + 4'd1;
                if (widx_q == 4'd15) begin
                    need_len_d = 1'b1;
                end
            end
            ST_LEN: begin
                wr_en  = 1'b1;
                wr_dat = (widx_q == 4'd14) ? len64[63:32] : len64[31:0];
                widx_d = widx_q + 4'd1;
                if (widx_q == 4'd15) begin
                    final_d = 1'b1;
                end
            end
            ST_EMIT: begin
                if (blk_hs) begin
                    buf_d      = '0;
                    widx_d     = 4'd0;
                    need_len_d = 1'b0;
                    final_d    = 1'b0;
                    // The block after a final one starts a new message.
                    first_d    = final_q;
                    if (final_q) begin
                        len_d = '0;
                    end
                end
            end
            default: ;
        endcase
        if (wr_en) begin
            buf_d[word_lsb(widx_q) +: WORD_W] = wr_dat;
        end
        in_ready_d = (state_d == ST_ACCEPT);
    end

    // Datapath registers; in_ready stays low through reset and rises one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            widx_q     <= 4'd0;
            buf_q      <= '0;
            len_q      <= '0;
            pend80_q   <= 1'b0;
            need_len_q <= 1'b0;
            first_q    <= 1'b1;
            final_q    <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            widx_q     <= widx_d;
            buf_q      <= buf_d;
            len_q      <= len_d;
            pend80_q   <= pend80_d;
            need_len_q <= need_len_d;
            first_q    <= first_d;
            final_q    <= final_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_sha1_padder.sv
// tb_sha1_padder: randomized self-checking bench for sha1_padder against a byte-level padding model.
// Latency: n/a (testbench).
// Backpressure: exercises held blk_ready and idle gaps on the input side.
module tb_sha1_padder;
    import sha1_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'h0;
    logic         in_last = 1'b0;
    logic [1:0]   in_bytes = 2'd0;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic [511:0] block;
    logic         blk_first;
    logic         blk_final;

    always #5 clk = ~clk;

    sha1_padder #(.LEN_W(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .block     (block),
        .blk_first (blk_first),
        .blk_final (blk_final)
    );

    logic [31:0]  msg_w[$];
    logic [31:0]  drv_w[$];
    bit           drv_last[$];
    logic [1:0]   drv_lb[$];
    logic [511:0] exp_blk[$];
    bit           exp_first[$];
    bit           exp_final[$];
    logic [511:0] got_blk[$];
    logic         got_first[$];
    logic         got_final[$];
    int           checks = 0;
    int           failures = 0;
    bit           drv_to = 1'b0;
    bit           drv_gap = 1'b0;

    // Reference SHA-1 compression, used to chain captured blocks into a digest.
    function automatic logic [159:0] sha1_compress(input logic [159:0] h, input logic [511:0] blk);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int t = 0; t < 16; t++) w[t] = blk[32*(15-t) +: 32];
        for (int t = 16; t < 80; t++) begin
            tmp  = w[t-3] ^ w[t-8] ^ w[t-14] ^ w[t-16];
            w[t] = {tmp[30:0], tmp[31]};
        end
        {a, b, c, d, e} = h;
        for (int t = 0; t < 80; t++) begin
            if (t < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
            else if (t < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
            else if (t < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
            else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
            tmp = {a[26:0], a[31:27]} + f + e + k + w[t];
            e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    // Model: flatten msg_w to bytes, append 0x80, zero-fill to 56 mod 64, append
    // 64-bit bit length, then slice into blocks. Also queues the words for the driver.
    task automatic model_build(input logic [1:0] lb);
        byte unsigned by[$];
        int           nb, n, nblk;
        logic [63:0]  bitlen;
        logic [511:0] blk;
`ifdef SHA1_PADDER_BYTE_EN
        nb = (lb == 2'd0) ? 4 : int'(lb);
`else
        nb = 4;
`endif
        for (int i = 0; i < msg_w.size(); i++) begin
            n = (i == msg_w.size() - 1) ? nb : 4;
            for (int j = 0; j < n; j++) by.push_back(msg_w[i][31-8*j -: 8]);
            drv_w.push_back(msg_w[i]);
            drv_last.push_back(i == msg_w.size() - 1);
            drv_lb.push_back((i == msg_w.size() - 1) ? lb : 2'($urandom));
        end
        bitlen = 64'(by.size()) * 64'd8;
        by.push_back(8'h80);
        while (by.size() % 64 != 56) by.push_back(8'h00);
        for (int j = 7; j >= 0; j--) by.push_back(bitlen[8*j +: 8]);
        nblk = by.size() / 64;
        for (int bi = 0; bi < nblk; bi++) begin
            blk = '0;
            for (int j = 0; j < 64; j++) blk[8*(63-j) +: 8] = by[64*bi + j];
            exp_blk.push_back(blk);
            exp_first.push_back(bi == 0);
            exp_final.push_back(bi == nblk - 1);
        end
        msg_w.delete();
    endtask

    task automatic clear_all();
        msg_w.delete(); drv_w.delete(); drv_last.delete(); drv_lb.delete();
        exp_blk.delete(); exp_first.delete(); exp_final.delete();
        got_blk.delete(); got_first.delete(); got_final.delete();
        drv_to = 1'b0;
    endtask

    // Drives every queued word; called at a falling edge, returns at a falling edge.
    task automatic drive_all();
        int t;
        while (drv_w.size() > 0) begin
            in_valid = 1'b1;
            in_data  = drv_w[0];
            in_last  = drv_last[0];
            in_bytes = drv_lb[0];
            t = 0;
            while (in_ready !== 1'b1 && t < 400) begin @(negedge clk); t++; end
            if (in_ready !== 1'b1) begin drv_to = 1'b1; break; end
            @(negedge clk);
            void'(drv_w.pop_front()); void'(drv_last.pop_front()); void'(drv_lb.pop_front());
            in_valid = 1'b0;
            in_last  = 1'b0;
            if (drv_gap) repeat ($urandom_range(2, 0)) @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Captures n blocks, optionally stalling blk_ready for a few random cycles.
    task automatic collect(input int n, input int unsigned hold_max);
        int t;
        for (int b = 0; b < n; b++) begin
            t = 0;
            while (blk_valid !== 1'b1 && t < 400) begin @(negedge clk); t++; end
            if (blk_valid !== 1'b1) return;
            if (hold_max > 0) repeat ($urandom_range(hold_max, 0)) @(negedge clk);
            got_blk.push_back(block);
            got_first.push_back(blk_first);
            got_final.push_back(blk_final);
            blk_ready = 1'b1;
            @(negedge clk);
            blk_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL rst_blk_valid got=%b exp=0", blk_valid); end
        checks++; if (block !== 512'd0) begin failures++; $display("FAIL rst_block got=%h exp=0", block); end
        checks++; if (blk_first !== 1'b0 || blk_final !== 1'b0) begin
            failures++; $display("FAIL rst_flags got=%b%b exp=00", blk_first, blk_final); end
        rst_n = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_release_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_ready_rise got=%b exp=1", in_ready); end
    endtask

    task automatic test_abc();
        logic [159:0] dg, de;
        clear_all();
        msg_w.push_back(32'h61626300);
        model_build(2'd3);
        fork drive_all(); collect(exp_blk.size(), 0); join
        checks++; if (drv_to || got_blk.size() != exp_blk.size()) begin
            failures++; $display("FAIL abc_count got=%0d exp=%0d drv_to=%0b", got_blk.size(), exp_blk.size(), drv_to); end
        for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            checks++;
            if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] || got_final[i] !== exp_final[i]) begin
                failures++;
                $display("FAIL abc_blk%0d got=%h f=%b%b exp=%h f=%b%b", i, got_blk[i], got_first[i], got_final[i],
                         exp_blk[i], exp_first[i], exp_final[i]);
            end
        end
        dg = SHA1_IV;
        foreach (got_blk[i]) dg = sha1_compress(dg, got_blk[i]);
`ifdef SHA1_PADDER_BYTE_EN
        de = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
`else
        de = SHA1_IV;
        foreach (exp_blk[i]) de = sha1_compress(de, exp_blk[i]);
`endif
        checks++; if (dg !== de) begin failures++; $display("FAIL abc_digest got=%h exp=%h", dg, de); end
    endtask

    task automatic test_overflow_len();
        clear_all();
        for (int i = 0; i < 14; i++) msg_w.push_back($urandom);
        model_build(2'd0);
        fork drive_all(); collect(exp_blk.size(), 0); join
        checks++; if (drv_to || got_blk.size() != 2) begin
            failures++; $display("FAIL ovf_count got=%0d exp=2 drv_to=%0b", got_blk.size(), drv_to); end
        for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            checks++;
            if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] || got_final[i] !== exp_final[i]) begin
                failures++;
                $display("FAIL ovf_blk%0d got=%h f=%b%b exp=%h f=%b%b", i, got_blk[i], got_first[i], got_final[i],
                         exp_blk[i], exp_first[i], exp_final[i]);
            end
        end
        if (got_blk.size() == 2) begin
            checks++; if (got_blk[0][63:32] !== 32'h80000000 || got_final[0] !== 1'b0) begin
                failures++; $display("FAIL ovf_marker got=%h final=%b exp=80000000 final=0", got_blk[0][63:32], got_final[0]); end
            checks++; if (got_blk[1][31:0] !== 32'h000001C0 || got_final[1] !== 1'b1) begin
                failures++; $display("FAIL ovf_len got=%h final=%b exp=000001c0 final=1", got_blk[1][31:0], got_final[1]); end
        end
    endtask

    task automatic test_full16();
        clear_all();
        for (int i = 0; i < 16; i++) msg_w.push_back($urandom);
        model_build(2'd0);
        fork drive_all(); collect(exp_blk.size(), 0); join
        checks++; if (drv_to || got_blk.size() != 2) begin
            failures++; $display("FAIL full16_count got=%0d exp=2 drv_to=%0b", got_blk.size(), drv_to); end
        for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            checks++;
            if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] || got_final[i] !== exp_final[i]) begin
                failures++;
                $display("FAIL full16_blk%0d got=%h f=%b%b exp=%h f=%b%b", i, got_blk[i], got_first[i], got_final[i],
                         exp_blk[i], exp_first[i], exp_final[i]);
            end
        end
        if (got_blk.size() == 2) begin
            checks++; if (got_blk[1][511:480] !== 32'h80000000 || got_blk[1][31:0] !== 32'h00000200) begin
                failures++; $display("FAIL full16_tail got=%h/%h exp=80000000/00000200", got_blk[1][511:480], got_blk[1][31:0]); end
        end
    endtask

    task automatic test_backpressure();
        logic [511:0] b0;
        logic         f0, l0;
        int           t;
        clear_all();
        msg_w.push_back($urandom);
        model_build(2'd0);
        drive_all();
        t = 0;
        while (blk_valid !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++; if (blk_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", blk_valid); end
        b0 = block; f0 = blk_first; l0 = blk_final;
        checks++; if (b0 !== exp_blk[0] || f0 !== exp_first[0] || l0 !== exp_final[0]) begin
            failures++; $display("FAIL bp_blk got=%h f=%b%b exp=%h f=%b%b", b0, f0, l0, exp_blk[0], exp_first[0], exp_final[0]); end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (block !== b0 || blk_first !== f0 || blk_final !== l0 || blk_valid !== 1'b1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d valid=%b in_ready=%b f=%b%b exp valid=1 in_ready=0 f=%b%b", c,
                         blk_valid, in_ready, blk_first, blk_final, f0, l0);
            end
            @(negedge clk);
        end
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release in_ready=%b valid=%b exp in_ready=1 valid=0", in_ready, blk_valid); end
    endtask

    task automatic test_reset_mid_fill();
        int n, t;
        clear_all();
        n = 0; t = 0;
        in_valid = 1'b1; in_last = 1'b0;
        while (n < 7 && t < 100) begin
            in_data = $urandom;
            if (in_ready === 1'b1) n++;
            @(negedge clk); t++;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_first !== 1'b0 || blk_final !== 1'b0) begin
            failures++; $display("FAIL midrst_ctl got=%b%b%b%b exp=0000", in_ready, blk_valid, blk_first, blk_final); end
        checks++; if (block !== 512'd0) begin failures++; $display("FAIL midrst_block got=%h exp=0", block); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        msg_w.push_back(32'h61626300);
        model_build(2'd3);
        fork drive_all(); collect(exp_blk.size(), 0); join
        checks++; if (drv_to || got_blk.size() != exp_blk.size()) begin
            failures++; $display("FAIL midrst_count got=%0d exp=%0d drv_to=%0b", got_blk.size(), exp_blk.size(), drv_to); end
        for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            checks++;
            if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] || got_final[i] !== exp_final[i]) begin
                failures++;
                $display("FAIL midrst_blk%0d got=%h f=%b%b exp=%h f=%b%b", i, got_blk[i], got_first[i], got_final[i],
                         exp_blk[i], exp_first[i], exp_final[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        for (int i = 0; i < 3; i++) msg_w.push_back($urandom);
        model_build(2'($urandom));
        for (int i = 0; i < 20; i++) msg_w.push_back($urandom);
        model_build(2'($urandom));
        fork drive_all(); collect(exp_blk.size(), 0); join
        checks++; if (drv_to || got_blk.size() != exp_blk.size()) begin
            failures++; $display("FAIL b2b_count got=%0d exp=%0d drv_to=%0b", got_blk.size(), exp_blk.size(), drv_to); end
        for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            checks++;
            if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] || got_final[i] !== exp_final[i]) begin
                failures++;
                $display("FAIL b2b_blk%0d got=%h f=%b%b exp=%h f=%b%b", i, got_blk[i], got_first[i], got_final[i],
                         exp_blk[i], exp_first[i], exp_final[i]);
            end
        end
    endtask

    task automatic test_random();
        int len;
        clear_all();
        for (int m = 0; m < 10; m++) begin
            len = (m < 4) ? 13 + m : int'($urandom_range(40, 1));
            for (int i = 0; i < len; i++) msg_w.push_back($urandom);
            model_build(2'($urandom));
        end
        drv_gap = 1'b1;
        fork drive_all(); collect(exp_blk.size(), 3); join
        drv_gap = 1'b0;
        checks++; if (drv_to || got_blk.size() != exp_blk.size()) begin
            failures++; $display("FAIL rand_count got=%0d exp=%0d drv_to=%0b", got_blk.size(), exp_blk.size(), drv_to); end
        for (int i = 0; i < exp_blk.size() && i < got_blk.size(); i++) begin
            checks++;
            if (got_blk[i] !== exp_blk[i] || got_first[i] !== exp_first[i] || got_final[i] !== exp_final[i]) begin
                failures++;
                $display("FAIL rand_blk%0d got=%h f=%b%b exp=%h f=%b%b", i, got_blk[i], got_first[i], got_final[i],
                         exp_blk[i], exp_first[i], exp_final[i]);
            end
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_abc();
        test_overflow_len();
        test_full16();
        test_backpressure();
        test_reset_mid_fill();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
